// File: rtl/fas_pkg.sv
// Shared FAS constants and the transmit state type used by the sample
// transmitter and the FIR/FFT chain.
package fas_pkg;
  localparam int FRAME_LEN = 16;
  localparam int SAMPLE_W  = 16;
  localparam int GAP_W     = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} tx_state_t;
endpackage

// File: rtl/fas_pingpong_buf.sv
// Two-bank frame store: one synchronous write port and one combinational
// read port. No reset; validity is tracked by the per-bank counts outside.
module fas_pingpong_buf #(
  parameter int FRAME_LEN = 16,
  parameter int W         = 16,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_data
);
  logic [1:0][FRAME_LEN-1:0][W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_bank][wr_idx] <= wr_data;
  end

  assign rd_data = mem_q[rd_bank][rd_idx];
endmodule

// File: rtl/fas_sample_tx.sv
// Ping-pong framed sample transmitter: fills one bank while the other is
// sent as a paced FRAME_LEN-beat burst of data_valid toward FAS.
module fas_sample_tx #(
  parameter int FRAME_LEN = 16,
  parameter int GAP       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        flush,
  output logic        data_valid,
  output logic [15:0] data,
  output logic        frame_done,
  output logic        busy
);
  import fas_pkg::*;

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_C    = GAP_W'(GAP);

  tx_state_t                 state_q, state_d;
  logic [1:0]                full_q, full_d;
  logic [1:0][CNT_W-1:0]     count_q, count_d;
  logic                      wb_q, wb_d, rb_q, rb_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [GAP_W-1:0]          gap_cnt_q, gap_cnt_d;
  logic                      data_valid_q, data_valid_d;
  logic [SAMPLE_W-1:0]       data_q, data_d;
  logic                      frame_done_q, frame_done_d;
  logic                      busy_q, busy_d;

  logic                      wr_acc, fill_close, launch, beat, last, other_full;
  logic [CNT_W-1:0]          cnt_wr;
  logic [IDX_W-1:0]          beat_idx;
  logic [SAMPLE_W-1:0]       rd_data;

  fas_pingpong_buf #(.FRAME_LEN(FRAME_LEN), .W(SAMPLE_W), .IDX_W(IDX_W)) u_buf (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_bank (wb_q),
    .wr_idx  (count_q[wb_q][IDX_W-1:0]),
    .wr_data (wr_data),
    .rd_bank (rb_q),
    .rd_idx  (beat_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    wr_ready   = !full_q[wb_q];
    wr_acc     = wr_valid && wr_ready && !rst;
    cnt_wr     = count_q[wb_q] + CNT_W'(wr_acc);
    // A flush closes whatever is in the bank including a same-cycle write.
    fill_close = !full_q[wb_q] && ((wr_acc && cnt_wr == LEN_C) || (flush && cnt_wr != '0));
    launch     = full_q[rb_q] && (state_q == ST_IDLE || (state_q == ST_GAP && gap_cnt_q == GAP_C));
    beat       = launch || state_q == ST_SEND;
    beat_idx   = (state_q == ST_SEND) ? idx_q : '0;
    last       = beat && beat_idx == LAST_IDX;
    // Count a bank closing on this very edge so GAP=0 streams stay contiguous.
    other_full = full_q[!rb_q] || (fill_close && wb_q != rb_q);
  end

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    count_d      = count_q;
    wb_d         = wb_q;
    rb_d         = rb_q;
    idx_d        = idx_q;
    gap_cnt_d    = gap_cnt_q;
    data_valid_d = 1'b0;
    data_d       = '0;
    frame_done_d = 1'b0;

    if (wr_acc) count_d[wb_q] = cnt_wr;
    if (fill_close) begin
      full_d[wb_q] = 1'b1;
      wb_d         = !wb_q;
    end

    if (state_q == ST_GAP) begin
      if (gap_cnt_q != GAP_C) gap_cnt_d = gap_cnt_q + 1'b1;
      else if (!full_q[rb_q]) state_d = ST_IDLE;
    end

    if (beat) begin
      data_valid_d = 1'b1;
      data_d       = (CNT_W'(beat_idx) < count_q[rb_q]) ? rd_data : '0;
      idx_d        = beat_idx + 1'b1;
      state_d      = ST_SEND;
      if (last) begin
        frame_done_d  = 1'b1;
        full_d[rb_q]  = 1'b0;
        count_d[rb_q] = '0;
        rb_d          = !rb_q;
        idx_d         = '0;
        if (GAP > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else if (other_full) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end

    busy_d = data_valid_d || (state_d == ST_SEND) || (|full_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      full_q       <= '0;
      count_q      <= '0;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      idx_q        <= '0;
      gap_cnt_q    <= '0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      count_q      <= count_d;
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      idx_q        <= idx_d;
      gap_cnt_q    <= gap_cnt_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign data_valid = data_valid_q;
  assign data       = data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
endmodule
